// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register and next-PC selection (seq/beq/j/jr) with
// start/stall/halt control, self-loop halt and saturating fetch counter.
// Ports: clk, reset (async, active-high), start, stall, branch_taken,
//   branch_off[15:0], jump, jump_target[25:0], jr, jr_target[31:0] in;
//   pc, pc_plus4, fetch_valid, halted, err, fetch_count[15:0] out.
// Optional: define FETCH_BOUNDS_CHECK_EN to halt with err on a target
//   outside the 4*2^DEPTH_W byte instruction memory or not word aligned.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH_W  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_off,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        halted,
   output logic        err,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] next_pc;
   logic [31:0] br_off;
   logic        redirect;
   logic        self_loop;
   logic        bad;

   assign pc_plus4 = pc_q + 32'd4;
   assign br_off   = {{14{branch_off[15]}}, branch_off, 2'b00};
   assign redirect = jr | jump | branch_taken;

   always_comb begin
      next_pc = pc_plus4;
      if (jr)
         next_pc = jr_target;
      else if (jump)
         next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      else if (branch_taken)
         next_pc = pc_plus4 + br_off;
   end

   // a redirect back onto itself (e.g. beq $0,$0,-1) marks program end
   assign self_loop = redirect && (next_pc == pc_q);

`ifdef FETCH_BOUNDS_CHECK_EN
   assign bad = (|(next_pc >> (DEPTH_W + 2))) | (|next_pc[1:0]);
`else
   // index simply wraps in the memory; err can never be set
   assign bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d = RUN;
               pc_d    = RESET_PC;
               err_d   = 1'b0;
               cnt_d   = 16'd0;
            end
         end
         RUN: begin
            if (!stall) begin
               if (cnt_q != 16'hFFFF)
                  cnt_d = cnt_q + 16'd1;
               // bounds check outranks self-loop; pc keeps the bad fetch
               if (bad) begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end else if (self_loop) begin
                  state_d = HALT;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc          = pc_q;
   assign fetch_valid = (state_q == RUN) && !stall;
   assign halted      = (state_q == HALT);
   assign err         = err_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plan steps then randomized steps, each
// compared against a behavioural PC model.
module tb_fetch_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_off = '0;
   logic        jump = 1'b0;
   logic [25:0] jump_target = '0;
   logic        jr = 1'b0;
   logic [31:0] jr_target = '0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        halted;
   logic        err;
   logic [15:0] fetch_count;

   int vectors = 0;
   int misses  = 0;

   // behavioural model state
   logic [31:0] m_pc;
   bit          m_run;
   bit          m_halt;
   bit          m_err;
   int          m_cnt;

   fetch_sequencer #(.RESET_PC(RST_PC), .DEPTH_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .branch_taken(branch_taken), .branch_off(branch_off),
      .jump(jump), .jump_target(jump_target),
      .jr(jr), .jr_target(jr_target),
      .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
      .halted(halted), .err(err), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         misses++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = RST_PC;
      m_run  = 0;
      m_halt = 0;
      m_err  = 0;
      m_cnt  = 0;
   endtask

   // one clock edge of the program-counter rules
   task automatic model_edge();
      logic [31:0] nxt;
      int          so;
      bit          redir;
      bit          oob;
      if (start && !m_run) begin
         m_pc   = RST_PC;
         m_run  = 1;
         m_halt = 0;
         m_err  = 0;
         m_cnt  = 0;
      end else if (m_run && !stall) begin
         so    = $signed(branch_off);
         redir = jr || jump || branch_taken;
         if (jr)
            nxt = jr_target;
         else if (jump)
            nxt = ((m_pc + 4) & 32'hF000_0000) + {4'd0, jump_target, 2'd0};
         else if (branch_taken)
            nxt = m_pc + 4 + 32'(so * 4);
         else
            nxt = m_pc + 4;
         oob = 0;
`ifdef FETCH_BOUNDS_CHECK_EN
         oob = (nxt >= 32'd1024) || (nxt % 4 != 0);
`endif
         if (m_cnt < 65535)
            m_cnt++;
         if (oob) begin
            m_err  = 1;
            m_run  = 0;
            m_halt = 1;
         end else if (redir && nxt == m_pc) begin
            m_run  = 0;
            m_halt = 1;
         end else begin
            m_pc = nxt;
         end
      end
   endtask

   task automatic check_all();
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_run && !stall});
      check("halted", {31'd0, halted}, {31'd0, m_halt});
      check("err", {31'd0, err}, {31'd0, m_err});
      check("fetch_count", {16'd0, fetch_count}, 32'(m_cnt));
   endtask

   task automatic step(input bit st, input bit sl, input bit bt,
                       input logic [15:0] bo, input bit j,
                       input logic [25:0] jt, input bit r,
                       input logic [31:0] rt);
      start        = st;
      stall        = sl;
      branch_taken = bt;
      branch_off   = bo;
      jump         = j;
      jump_target  = jt;
      jr           = r;
      jr_target    = rt;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      model_reset();
      #1;
      check_all();
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      check_all();

      // launch and sequential fetch
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("plan_pc0", pc, 32'd0);
      check("plan_fv", {31'd0, fetch_valid}, 32'd1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("plan_pc12", pc, 32'd12);
      check("plan_cnt3", {16'd0, fetch_count}, 32'd3);

      // stall beats a pending branch, then it lands
      for (int i = 0; i < 3; i++)
         step(0, 1, 1, 16'd2, 0, 0, 0, 0);
      check("stall_pc", pc, 32'd12);
      check("stall_cnt", {16'd0, fetch_count}, 32'd3);
      step(0, 0, 1, 16'd2, 0, 0, 0, 0);
      check("release_pc", pc, 32'd24);

      // jump to 48, branch back to 20, then self-loop
      step(0, 0, 0, 0, 1, 26'd12, 0, 0);
      check("jump_pc48", pc, 32'd48);
      step(0, 0, 1, 16'hFFF8, 0, 0, 0, 0);
      check("branch_pc20", pc, 32'd20);
      step(0, 0, 1, 16'hFFFF, 0, 0, 0, 0);
      check("loop_halted", {31'd0, halted}, 32'd1);
      check("loop_pc", pc, 32'd20);
      check("loop_cnt", {16'd0, fetch_count}, 32'd7);
      step(0, 0, 0, 0, 1, 26'd3, 0, 0);
      check("halt_frozen", pc, 32'd20);

      // restart with stall high, then jump/jr priority
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 26'd16, 0, 0);
      check("jump_pc64", pc, 32'd64);
      step(0, 0, 0, 0, 1, 26'd20, 0, 0);
      check("jump_pc80", pc, 32'd80);
      step(1, 0, 1, 16'd1, 1, 26'd5, 1, 32'h64);
      check("jr_wins", pc, 32'd100);

`ifdef FETCH_BOUNDS_CHECK_EN
      step(0, 0, 0, 0, 0, 0, 1, 32'h400);
      check("oob_err", {31'd0, err}, 32'd1);
      check("oob_pc", pc, 32'd100);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("oob_clear", {31'd0, err}, 32'd0);
      step(0, 0, 0, 0, 0, 0, 1, 32'h2);
      check("misalign_err", {31'd0, err}, 32'd1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
`endif

      // asynchronous reset between edges
      step(0, 0, 0, 0, 0, 0, 0, 0);
      #3 reset = 1'b1;
      #1;
      model_reset();
      check("areset_pc", pc, RST_PC);
      check("areset_fv", {31'd0, fetch_valid}, 32'd0);
      check_all();
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      check_all();
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("idle_no_start", {31'd0, fetch_valid}, 32'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit          st, sl, bt, j, r;
         logic [15:0] bo;
         logic [25:0] jt;
         logic [31:0] rt;
         st = m_run ? ($urandom_range(0, 19) == 0)
                    : ($urandom_range(0, 2) == 0);
         sl = ($urandom_range(0, 4) == 0);
         bt = ($urandom_range(0, 3) == 0);
         j  = ($urandom_range(0, 9) == 0);
         r  = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 7))
            0:       bo = 16'($urandom);
            1:       bo = 16'hFFFF;
            default: bo = 16'($urandom_range(0, 15)) - 16'd8;
         endcase
         if ($urandom_range(0, 7) == 0)
            jt = 26'($urandom);
         else
            jt = 26'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0)
            rt = $urandom;
         else
            rt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         step(st, sl, bt, bo, j, jt, r, rt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer for the single-cycle MIPS core. Owns the PC register that drives the 256-word instruction memory. Each cycle it selects the next PC from four sources: sequential, beq-taken, j/jal, and jr. It also provides start/stall/halt control so a bench or top level can launch, freeze and detect completion of a program.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and on every start.
- DEPTH_W, 8, instruction memory word-index width; legal PCs are below 4·2^DEPTH_W.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, single-cycle pulse; leaves IDLE/HALT and begins fetching at RESET_PC.
- stall, input, 1, freezes the PC and all state while high.
- branch_taken, input, 1, beq resolved taken for the current pc.
- branch_off, input, 16, signed word offset from the beq immediate.
- jump, input, 1, j or jal for the current pc.
- jump_target, input, 26, instruction index field.
- jr, input, 1, jr for the current pc.
- jr_target, input, 32, register value for jr.
- pc, output, 32, instruction memory address.
- pc_plus4, output, 32, pc+4, used as the jal link value.
- fetch_valid, output, 1, instruction at pc executes this cycle.
- halted, output, 1, state is HALT.
- err, output, 1, sticky; set on a bad target.
- fetch_count, output, 16, number of executed fetches, saturating.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - HALT.
- IDLE:
  - pc holds RESET_PC.
  - fetch_valid = 0.
  - start moves the block to RUN.
- RUN:
  - fetch_valid = !stall.
  - On each edge with fetch_valid = 1, pc <= next_pc.
- next_pc priority: jr > jump > branch_taken > sequential.
  - jr: jr_target.
  - jump: {pc_plus4[31:28], jump_target, 2'b00}.
  - branch: pc_plus4 + (sign_ext(branch_off) << 2), computed modulo 2^32.
  - sequential: pc_plus4.
- Redirect inputs are ignored when fetch_valid = 0.
- Self-loop detection:
  - Trigger: a redirect (jr, jump or branch) with next_pc == pc while fetch_valid = 1.
  - Response: go to HALT; pc is unchanged.
  - Example: beq $0,$0,-1 halts.
- HALT:
  - pc is frozen.
  - fetch_valid = 0.
  - halted = 1.
  - start reloads RESET_PC, clears err and fetch_count, and enters RUN.
- start during RUN is ignored.
- fetch_count:
  - Increments on every edge with fetch_valid = 1, including the fetch that causes HALT.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by start.

## Timing
- Reset values:
  - pc = RESET_PC.
  - pc_plus4 = RESET_PC+4.
  - fetch_valid = 0, halted = 0, err = 0, fetch_count = 0.
  - State = IDLE.
- Reset mid-RUN takes effect immediately (asynchronous), with no edge needed.
- start pulse at edge N gives fetch_valid = 1 in cycle N+1, with pc = RESET_PC.
- Zero latency from redirect to PC: a redirect sampled at edge N appears on pc in cycle N+1.
- pc_plus4 is combinational from pc.
- stall and redirect in the same cycle: stall wins. The datapath must hold the redirect until stall drops.
- stall high in IDLE/HALT has no effect; start is still honoured.
- HALT entry: halted rises in the cycle after the offending fetch.

## Configuration
Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - Check: a candidate next_pc with bits [31:DEPTH_W+2] nonzero or bits [1:0] nonzero is bad.
  - Response to a bad candidate: not loaded into pc; err <= 1; state <= HALT.
  - Priority: the bounds check beats self-loop detection.
- Undefined:
  - No check is made; err is tied to 0.
  - next_pc is loaded unconditionally; the memory sees only PC[DEPTH_W+1:2], so the index wraps.

## Test plan
- Reset then start: pc = 0, 4, 8, 12 on successive cycles; fetch_count = 3 after the third edge.
- At pc = 48, branch_taken with branch_off = 16'hFFF8: next pc = 20. Continue with branch_off = 16'hFFFF at pc = 20: halted = 1, pc holds 20, fetch_count counts the halting fetch.
- At pc = 64, jump with jump_target = 20: pc = 80. Then jr, jump and branch_taken all asserted with jr_target = 32'h64: pc = 100, because jr wins.
- stall held 3 cycles at pc = 12 with branch_taken asserted: pc stays 12 and fetch_count is unchanged. On release: pc = pc_plus4 + offset.
- FETCH_BOUNDS_CHECK_EN defined, jr_target = 32'h400 or 32'h2: err = 1, halted = 1, pc is unchanged. Then start: pc = 0, err = 0.
- Reset asserted mid-RUN between edges: pc = RESET_PC and fetch_valid = 0 immediately. Start is required to resume.
